switch_cfg_ctrl: RTL and testbench
==================================

# switch_cfg_ctrl

Configuration sequencer for the 4-port switch. It accepts a configuration request carrying four port addresses and a packed priority word. It then gates new ingress writes, waits for the switch FIFOs to drain, and programs the switch through its port-config and priority-write inputs. Finally it re-enables the ports and traffic. It sits between the test/system control layer and the switch's `port_*`/`prio_*` pins, and its `wr_gate` output is honoured by every ingress driver.

## Interface
Parameters:
- `NPORTS`, 4, number of switch ports
- `AW`, 16, per-port address width
- `PW`, 8, priority word width (2 bits per port)
- `DRAIN_TIMEOUT`, 255, max cycles spent waiting for FIFOs to empty (1..255)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge resets all state
- `cfg_req`  in  1  request to (re)configure; sampled only in IDLE
- `cfg_addr`  in  NPORTS*AW  port i address in bits [AW*i+AW-1 : AW*i]
- `cfg_prio`  in  PW  priority word, passed unchanged to `prio_val`
- `fifo_empty`  in  NPORTS  switch FIFO-empty flags
- `cfg_busy`  out  1  high in every state except IDLE
- `cfg_done`  out  1  one-cycle pulse on successful completion
- `cfg_err`  out  1  one-cycle pulse on drain timeout
- `wr_gate`  out  1  1 = ingress writes allowed
- `port_en`  out  1  switch port enable
- `port_wr`  out  1  port address write strobe
- `port_sel`  out  2  port index for `port_wr`
- `port_addr`  out  AW  address written on `port_wr`
- `prio_val`  out  PW  priority value
- `prio_wr`  out  1  priority write strobe

## Operation
- FSM states:
  - IDLE
  - GATE: 2 cycles
  - DRAIN: at least 1 cycle
  - WADDR: 4 cycles, one per port
  - WPRIO: 1 cycle
  - DONE: 1 cycle
  - ERR: 1 cycle
- Transitions:
  - IDLE → GATE when `cfg_req==1`. At that edge, `cfg_addr` and `cfg_prio` are latched into shadow registers, and the current `wr_gate` is saved as `gate_prev`.
  - GATE: `wr_gate=0`. After 2 cycles → DRAIN, covering in-flight writes.
  - DRAIN: `wr_gate=0`. → WADDR in the cycle after `fifo_empty==4'hF` is sampled.
  - WADDR: `port_en=0`, `port_wr=1`, `port_sel` = 0,1,2,3 on consecutive cycles, `port_addr` = latched address of that port. → WPRIO after index 3.
  - WPRIO: `prio_wr=1`, `prio_val` = latched priority. → DONE.
  - DONE: `cfg_done=1`, `port_en=1`, `wr_gate=1`. Sets internal `configured` flag. → IDLE.
  - ERR: `cfg_err=1`; `wr_gate` restored to `gate_prev`; `port_en` unchanged; no writes issued. → IDLE.
- `cfg_req` arriving while `cfg_busy` is ignored (not queued). A request held high through DONE starts a new sequence from IDLE on the next edge.
- Outside WADDR/WPRIO, strobes are 0, while `port_sel`, `port_addr` and `prio_val` hold their last values.
- Reset mid-sequence returns to IDLE with reset values. The partially written configuration is abandoned, and `configured` is cleared.

## Timing
- All outputs registered; reset values are 0 for every output, including `wr_gate` and `port_en`, so traffic is blocked until the first successful config.
- Minimum latency with FIFOs already empty: request accepted at edge N. GATE occupies cycles N+1..N+2, DRAIN N+3, WADDR N+4..N+7, WPRIO N+8, DONE (`cfg_done`) N+9.
- Port enable, gate and done all rise together in the DONE cycle.
- `cfg_done` and `cfg_err` are never high simultaneously; each is exactly 1 cycle.

## Configuration
- Macro `SWITCH_CFG_DRAIN_TIMEOUT_EN`.
- Defined: DRAIN counts cycles from entry. If `fifo_empty!=4'hF` after `DRAIN_TIMEOUT` cycles in DRAIN, → ERR.
- Undefined: DRAIN waits indefinitely; `cfg_err` tied to 0; ERR state and counter not compiled.

## Structure
- Package `switch_cfg_pkg`:
  - state enum `cfg_state_t`
  - `NPORTS`, `AW`, `PW` constants
  - `GATE_CYCLES=2`
  - default `DRAIN_TIMEOUT`
- Sub-module `cfg_timeout_cnt`: 8-bit saturating counter with clear/enable/expired. Instantiated only under `SWITCH_CFG_DRAIN_TIMEOUT_EN`.

## Test plan
- Reset then `cfg_req` with `cfg_addr=64'h0004_0003_0002_0001`, `cfg_prio=8'hE4`, FIFOs empty → `port_wr` on N+4..N+7 with sel 0..3 and addr 1..4; `prio_wr` with E4 at N+8; `cfg_done`, `port_en` and `wr_gate` high at N+9.
- Hold `fifo_empty=4'hE` for 20 cycles, then `4'hF` → `wr_gate=0` throughout; `port_wr` starts the cycle after empty is seen; `cfg_done` follows.
- Macro defined, `DRAIN_TIMEOUT=10`, `fifo_empty=4'h0` forever → `cfg_err` pulse after 10 DRAIN cycles; no `port_wr`/`prio_wr`; `wr_gate` returns to its prior value (0 on first config, 1 after a prior success).
- Second `cfg_req` pulsed during WADDR → ignored; exactly 4 `port_wr` and 1 `prio_wr`, single `cfg_done`.
- Assert `reset=0` during WADDR at sel=2 → next cycle all outputs 0, state IDLE; a new request then completes normally.
- `cfg_req` held high continuously → back-to-back sequences, each with `cfg_done` spaced 10 cycles apart with empty FIFOs.

Source files
------------

// File: rtl/switch_cfg_pkg.sv
// switch_cfg_pkg: shared state type and constants for the switch configuration sequencer
package switch_cfg_pkg;
  localparam int NPORTS = 4;
  localparam int AW = 16;
  localparam int PW = 8;
  localparam int GATE_CYCLES = 2;
  localparam int DRAIN_TIMEOUT = 255;
  typedef enum logic [2:0] {IDLE, GATE, DRAIN, WADDR, WPRIO, DONE, ERR} cfg_state_t;
endpackage

// File: rtl/switch_cfg_ctrl_if.sv
// switch_cfg_ctrl_if: request side and switch-programming side signals of switch_cfg_ctrl
interface switch_cfg_ctrl_if;
  import switch_cfg_pkg::*;
  logic cfg_req;
  logic [NPORTS*AW-1:0] cfg_addr;
  logic [PW-1:0] cfg_prio;
  logic [NPORTS-1:0] fifo_empty;
  logic cfg_busy;
  logic cfg_done;
  logic cfg_err;
  logic wr_gate;
  logic port_en;
  logic port_wr;
  logic [1:0] port_sel;
  logic [AW-1:0] port_addr;
  logic [PW-1:0] prio_val;
  logic prio_wr;
  modport master (
    output cfg_req, cfg_addr, cfg_prio, fifo_empty,
    input cfg_busy, cfg_done, cfg_err, wr_gate, port_en, port_wr, port_sel, port_addr, prio_val, prio_wr
  );
  modport slave (
    input cfg_req, cfg_addr, cfg_prio, fifo_empty,
    output cfg_busy, cfg_done, cfg_err, wr_gate, port_en, port_wr, port_sel, port_addr, prio_val, prio_wr
  );
endinterface

// File: rtl/cfg_timeout_cnt.sv
// cfg_timeout_cnt: 8-bit saturating cycle counter, expired once LIMIT counted cycles are in progress (SWITCH_CFG_DRAIN_TIMEOUT_EN only)
`ifdef SWITCH_CFG_DRAIN_TIMEOUT_EN
module cfg_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input logic clk,
  input logic reset,
  input logic clr,
  input logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!reset || clr) ? '0 : (en && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
  assign expired = cnt >= 8'(LIMIT - 1);
endmodule
`endif

// File: rtl/switch_cfg_ctrl.sv
// switch_cfg_ctrl: gates ingress, drains switch FIFOs, programs port addresses and priority; SWITCH_CFG_DRAIN_TIMEOUT_EN adds a drain timeout
module switch_cfg_ctrl #(
  parameter int NPORTS = switch_cfg_pkg::NPORTS,
  parameter int AW = switch_cfg_pkg::AW,
  parameter int PW = switch_cfg_pkg::PW
`ifdef SWITCH_CFG_DRAIN_TIMEOUT_EN
  , parameter int DRAIN_TIMEOUT = switch_cfg_pkg::DRAIN_TIMEOUT
`endif
) (
  input logic clk,
  input logic reset,
  switch_cfg_ctrl_if.slave bus
);
  import switch_cfg_pkg::*;
  cfg_state_t st, nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [NPORTS*AW-1:0] addr_sh;
  logic [PW-1:0] prio_sh;
  logic configured;
  logic drained;
  logic gate_last, addr_last;
  assign drained = &bus.fifo_empty;
  assign gate_last = cnt == 2'(GATE_CYCLES - 1);
  assign addr_last = cnt == 2'(NPORTS - 1);
`ifdef SWITCH_CFG_DRAIN_TIMEOUT_EN
  logic gate_prev, expired;
  cfg_timeout_cnt #(.LIMIT(DRAIN_TIMEOUT)) u_tmo (
    .clk(clk),
    .reset(reset),
    .clr(st != DRAIN),
    .en(st == DRAIN),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      gate_prev <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      if (st == IDLE && bus.cfg_req) gate_prev <= bus.wr_gate;
      bus.cfg_err <= nxt == ERR;
    end
  end
`else
  assign bus.cfg_err = 1'b0;
`endif
  always_comb begin
    nxt = st;
    cnt_nxt = '0;
    case (st)
      IDLE: nxt = bus.cfg_req ? GATE : IDLE;
      GATE: begin
        nxt = gate_last ? DRAIN : GATE;
        cnt_nxt = gate_last ? 2'd0 : cnt + 2'd1;
      end
`ifdef SWITCH_CFG_DRAIN_TIMEOUT_EN
      DRAIN: nxt = drained ? WADDR : expired ? ERR : DRAIN;
`else
      DRAIN: nxt = drained ? WADDR : DRAIN;
`endif
      WADDR: begin
        nxt = addr_last ? WPRIO : WADDR;
        cnt_nxt = addr_last ? 2'd0 : cnt + 2'd1;
      end
      WPRIO: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= IDLE;
      cnt <= '0;
      addr_sh <= '0;
      prio_sh <= '0;
      configured <= 1'b0;
      bus.cfg_busy <= 1'b0;
      bus.cfg_done <= 1'b0;
      bus.wr_gate <= 1'b0;
      bus.port_en <= 1'b0;
      bus.port_wr <= 1'b0;
      bus.port_sel <= '0;
      bus.port_addr <= '0;
      bus.prio_val <= '0;
      bus.prio_wr <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= cnt_nxt;
      if (st == IDLE && bus.cfg_req) begin
        addr_sh <= bus.cfg_addr;
        prio_sh <= bus.cfg_prio;
      end
      configured <= configured | (nxt == DONE);
      bus.cfg_busy <= nxt != IDLE;
      bus.cfg_done <= nxt == DONE;
`ifdef SWITCH_CFG_DRAIN_TIMEOUT_EN
      bus.wr_gate <= (nxt == DONE) ? 1'b1 : (nxt == ERR) ? gate_prev : (nxt == GATE) ? 1'b0 : bus.wr_gate;
`else
      bus.wr_gate <= (nxt == DONE) ? 1'b1 : (nxt == GATE) ? 1'b0 : bus.wr_gate;
`endif
      bus.port_en <= (nxt == DONE) | (configured & (nxt != WADDR) & (nxt != WPRIO));
      bus.port_wr <= nxt == WADDR;
      if (nxt == WADDR) begin
        bus.port_sel <= cnt_nxt;
        bus.port_addr <= addr_sh[AW*cnt_nxt +: AW];
      end
      bus.prio_wr <= nxt == WPRIO;
      if (nxt == WPRIO) bus.prio_val <= prio_sh;
    end
  end
endmodule

// File: tb/tb_switch_cfg_ctrl.sv
// tb_switch_cfg_ctrl: scoreboard bench for switch_cfg_ctrl
module tb_switch_cfg_ctrl;
  typedef struct {
    logic [1:0] kind;
    logic [17:0] data;
    int cyc;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  ev_t q[$];
  logic [32:0] outs;
  switch_cfg_ctrl_if bus();
`ifdef SWITCH_CFG_DRAIN_TIMEOUT_EN
  switch_cfg_ctrl #(.DRAIN_TIMEOUT(10)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  switch_cfg_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  assign outs = {bus.cfg_busy, bus.cfg_done, bus.cfg_err, bus.wr_gate, bus.port_en, bus.port_wr,
                 bus.port_sel, bus.port_addr, bus.prio_val, bus.prio_wr};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic got(input logic [1:0] kind, input logic [17:0] data);
    ev_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d data %0h at cycle %0d, expected no event", kind, data, cyc);
    end else begin
      e = q.pop_front();
      check("event{kind,data,cycle}", {kind, data, 32'(cyc)}, {e.kind, e.data, 32'(e.cyc)});
    end
  endtask
  task automatic push(input logic [1:0] kind, input logic [17:0] data, input int c);
    q.push_back('{kind, data, c});
  endtask
  task automatic push_seq(input int n, input int d, input logic [63:0] a, input logic [7:0] p, input int cut);
    for (int i = 0; i < cut && i < 4; i++) push(2'd0, {2'(i), a[16*i +: 16]}, n + 4 + d + i);
    if (cut > 4) push(2'd1, {10'd0, p}, n + 8 + d);
    if (cut > 5) push(2'd2, 18'd3, n + 9 + d);
  endtask
  task automatic start(input logic [63:0] a, input logic [7:0] p, input int d, input int cut, output int n);
    n = cyc;
    bus.cfg_addr = a;
    bus.cfg_prio = p;
    bus.cfg_req = 1'b1;
    push_seq(n, d, a, p, cut);
    @(negedge clk);
    bus.cfg_req = 1'b0;
  endtask
  always @(negedge clk) begin
    if (bus.port_wr) got(2'd0, {bus.port_sel, bus.port_addr});
    if (bus.prio_wr) got(2'd1, {10'd0, bus.prio_val});
    if (bus.cfg_done) got(2'd2, {16'd0, bus.port_en, bus.wr_gate});
    if (bus.cfg_err) got(2'd3, {16'd0, bus.port_en, bus.wr_gate});
    if (bus.port_wr || bus.prio_wr) check("write_gated{wr_gate,port_en}", {bus.wr_gate, bus.port_en}, 0);
    if (bus.cfg_done || bus.cfg_err) check("done_err_exclusive", bus.cfg_done & bus.cfg_err, 0);
  end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not end within 200000 time units");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n;
    bus.cfg_req = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_prio = '0;
    bus.fifo_empty = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_outs", outs, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_outs", outs, 0);
    start(64'h0004_0003_0002_0001, 8'hE4, 0, 6, n);
    repeat (10) @(negedge clk);
    check("idle_hold{sel,addr,prio}", {bus.port_sel, bus.port_addr, bus.prio_val}, {2'd3, 16'd4, 8'hE4});
    check("idle_en{busy,en,gate}", {bus.cfg_busy, bus.port_en, bus.wr_gate}, 3'b011);
    bus.fifo_empty = 4'hE;
    start(64'h1111_2222_3333_4444, 8'h1B, 20, 6, n);
    for (int k = 1; k <= 22; k++) begin
      check("drain{busy,gate,port_wr}", {bus.cfg_busy, bus.wr_gate, bus.port_wr}, 3'b100);
      @(negedge clk);
    end
    bus.fifo_empty = 4'hF;
    repeat (8) @(negedge clk);
    check("drain_idle{busy,gate}", {bus.cfg_busy, bus.wr_gate}, 2'b01);
    start(64'hBEEF_0C0C_00FF_A5A5, 8'h39, 0, 6, n);
    repeat (4) @(negedge clk);
    bus.cfg_req = 1'b1;
    @(negedge clk);
    bus.cfg_req = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_req_ignored", bus.cfg_busy, 0);
    start(64'h4444_3333_2222_1111, 8'hC6, 0, 3, n);
    repeat (5) @(negedge clk);
    check("sel_before_reset", bus.port_sel, 2);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_outs", outs, 0);
    reset = 1'b1;
    @(negedge clk);
`ifdef SWITCH_CFG_DRAIN_TIMEOUT_EN
    bus.fifo_empty = 4'h0;
    start(64'h0, 8'h55, 0, 0, n);
    push(2'd3, 18'd0, n + 13);
    repeat (14) @(negedge clk);
    bus.fifo_empty = 4'hF;
    check("err_first{busy,gate,en}", {bus.cfg_busy, bus.wr_gate, bus.port_en}, 0);
`endif
    start(64'h0123_4567_89AB_CDEF, 8'h4E, 0, 6, n);
    repeat (10) @(negedge clk);
    check("recover{en,gate}", {bus.port_en, bus.wr_gate}, 2'b11);
`ifdef SWITCH_CFG_DRAIN_TIMEOUT_EN
    bus.fifo_empty = 4'h0;
    start(64'hFFFF_FFFF_FFFF_FFFF, 8'hAA, 0, 0, n);
    push(2'd3, 18'd3, n + 13);
    repeat (14) @(negedge clk);
    bus.fifo_empty = 4'hF;
    check("err_after_ok{busy,gate,en}", {bus.cfg_busy, bus.wr_gate, bus.port_en}, 3'b011);
`endif
    n = cyc;
    bus.cfg_addr = 64'h000A_000B_000C_000D;
    bus.cfg_prio = 8'h93;
    bus.cfg_req = 1'b1;
    for (int s = 0; s < 3; s++) push_seq(n + 10 * s, 0, 64'h000A_000B_000C_000D, 8'h93, 6);
    repeat (21) @(negedge clk);
    bus.cfg_req = 1'b0;
    repeat (11) @(negedge clk);
    check("b2b_idle", bus.cfg_busy, 0);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
